// File: rtl/trace_matcher_pkg.sv
// rtl/trace_matcher_pkg.sv - shared constants and types for the trace matcher
// Purpose: frame-sync word, match counter width and sync FSM state encoding.
// Ports: none (package).
package trace_matcher_pkg;

    // Bytes FF,FF,FF,7F in arrival order, as they sit in the low word of the buffer.
    localparam logic [31:0] TRACE_FULL_SYNC = 32'hFFFF_FF7F;

    localparam int TRACE_COUNT_W = 8;

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_SYNCED = 1'b1
    } sync_state_e;

endpackage

// File: rtl/trace_rule_cmp.sv
// rtl/trace_rule_cmp.sv - one masked pattern rule with saturating hit counter
// Purpose: masked compare of the match buffer against one pattern; counts hits.
// Ports:
//   trace_clk, reset_i   clock, synchronous active-high reset
//   clear_i              resync clear of the counter
//   eval_i               buffer is comparable this cycle (synced, full, just shifted)
//   enable_i             rule enable
//   match_buf_i          current match buffer
//   pattern_i, mask_i    rule pattern and compare mask (1 = bit compared)
//   hit_o                combinational hit for this cycle
//   count_o              saturating hit count
module trace_rule_cmp
    import trace_matcher_pkg::*;
#(
    parameter int pBUFFER_SIZE = 64
) (
    input  logic                     trace_clk,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     eval_i,
    input  logic                     enable_i,
    input  logic [pBUFFER_SIZE-1:0]  match_buf_i,
    input  logic [pBUFFER_SIZE-1:0]  pattern_i,
    input  logic [pBUFFER_SIZE-1:0]  mask_i,
    output logic                     hit_o,
    output logic [TRACE_COUNT_W-1:0] count_o
);

    logic [TRACE_COUNT_W-1:0] count_q;
    logic [TRACE_COUNT_W-1:0] count_d;

    always_comb begin
        hit_o   = eval_i & enable_i & (((match_buf_i ^ pattern_i) & mask_i) == '0);
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (hit_o && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge trace_clk) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/trace_matcher.sv
// rtl/trace_matcher.sv - TPIU trace byte frame sync and multi-rule pattern matcher
// Purpose: shifts trace bytes into a match buffer, acquires frame sync on FF,FF,FF,7F,
//   compares the buffer against pMATCH_RULES masked patterns and reports pulses,
//   saturating counts, last matched data/rule and a capture trigger.
// Ports:
//   trace_clk, reset_i            clock, synchronous active-high reset
//   I_data, I_data_valid          incoming trace byte
//   I_reset_sync                  level, forces resync and clears buffer/counts/pulses
//   I_pattern_enable, I_trig_enable, I_patterns, I_masks   rule configuration
//   I_arm                         only with TRACE_MATCH_ARM_EN: rising edge arms the trigger
//   O_synchronized, O_match, O_trigger, O_counts, O_matched_data, O_matched_rule
// Configuration: TRACE_MATCH_ARM_EN adds the I_arm one-shot trigger arming.
module trace_matcher
    import trace_matcher_pkg::*;
#(
    parameter int pBUFFER_SIZE = 64,
    parameter int pMATCH_RULES = 8
) (
    input  logic                                   trace_clk,
    input  logic                                   reset_i,
    input  logic [7:0]                             I_data,
    input  logic                                   I_data_valid,
    input  logic                                   I_reset_sync,
`ifdef TRACE_MATCH_ARM_EN
    input  logic                                   I_arm,
`endif
    input  logic [pMATCH_RULES-1:0]                I_pattern_enable,
    input  logic [pMATCH_RULES-1:0]                I_trig_enable,
    input  logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   I_patterns,
    input  logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   I_masks,
    output logic                                   O_synchronized,
    output logic [pMATCH_RULES-1:0]                O_match,
    output logic                                   O_trigger,
    output logic [pMATCH_RULES*TRACE_COUNT_W-1:0]  O_counts,
    output logic [pBUFFER_SIZE-1:0]                O_matched_data,
    output logic [2:0]                             O_matched_rule
);

    localparam int FILL_MAX = pBUFFER_SIZE / 8;
    localparam int FILL_W   = $clog2(FILL_MAX + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FILL_MAX);

    sync_state_e               state_q, state_d;
    logic [pBUFFER_SIZE-1:0]   match_buf_q, match_buf_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic                      shifted_q, shifted_d;
    logic                      sync_q, sync_d;
    logic [pMATCH_RULES-1:0]   match_q, match_d;
    logic                      trig_q, trig_d;
    logic [pBUFFER_SIZE-1:0]   mdata_q, mdata_d;
    logic [2:0]                mrule_q, mrule_d;

    logic [pMATCH_RULES-1:0]   hit;
    logic                      eval;
    logic                      trig_fire;
    logic [2:0]                low_idx;

    // Compare only in the cycle after a shift so each byte yields at most one hit;
    // a resync in the same cycle suppresses the compare entirely.
    assign eval = shifted_q & (state_q == ST_SYNCED) & (fill_q == FILL_FULL) & ~I_reset_sync;

    for (genvar g = 0; g < pMATCH_RULES; g++) begin : g_rule
        trace_rule_cmp #(
            .pBUFFER_SIZE (pBUFFER_SIZE)
        ) u_cmp (
            .trace_clk   (trace_clk),
            .reset_i     (reset_i),
            .clear_i     (I_reset_sync),
            .eval_i      (eval),
            .enable_i    (I_pattern_enable[g]),
            .match_buf_i (match_buf_q),
            .pattern_i   (I_patterns[g*pBUFFER_SIZE +: pBUFFER_SIZE]),
            .mask_i      (I_masks[g*pBUFFER_SIZE +: pBUFFER_SIZE]),
            .hit_o       (hit[g]),
            .count_o     (O_counts[g*TRACE_COUNT_W +: TRACE_COUNT_W])
        );
    end

    // Descending scan so the lowest hitting index is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int i = pMATCH_RULES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                low_idx = 3'(i);
            end
        end
    end

`ifdef TRACE_MATCH_ARM_EN
    logic arm_prev_q, arm_prev_d;
    logic armed_q, armed_d;

    always_comb begin
        trig_fire  = armed_q & (|(hit & I_trig_enable));
        arm_prev_d = I_arm;
        armed_d    = (armed_q & ~trig_fire) | (I_arm & ~arm_prev_q);
        if (I_reset_sync) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge trace_clk) begin
        if (reset_i) begin
            arm_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            arm_prev_q <= arm_prev_d;
            armed_q    <= armed_d;
        end
    end
`else
    assign trig_fire = |(hit & I_trig_enable);
`endif

    always_comb begin
        state_d     = state_q;
        match_buf_d = match_buf_q;
        fill_d      = fill_q;
        shifted_d   = I_data_valid;
        match_d     = hit;
        trig_d      = trig_fire;
        mdata_d     = mdata_q;
        mrule_d     = mrule_q;

        if (|hit) begin
            mdata_d = match_buf_q;
            mrule_d = low_idx;
        end

        if (shifted_q && (state_q == ST_UNSYNC) && (match_buf_q[31:0] == TRACE_FULL_SYNC)) begin
            state_d = ST_SYNCED;
        end

        if (I_data_valid) begin
            match_buf_d = {match_buf_q[pBUFFER_SIZE-9:0], I_data};
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        // Resync discards any same-cycle byte; last-match snapshot is kept.
        if (I_reset_sync) begin
            state_d     = ST_UNSYNC;
            match_buf_d = '0;
            fill_d      = '0;
            shifted_d   = 1'b0;
            match_d     = '0;
            trig_d      = 1'b0;
        end

        sync_d = (state_d == ST_SYNCED);
    end

    always_ff @(posedge trace_clk) begin
        if (reset_i) begin
            state_q     <= ST_UNSYNC;
            match_buf_q <= '0;
            fill_q      <= '0;
            shifted_q   <= 1'b0;
            sync_q      <= 1'b0;
            match_q     <= '0;
            trig_q      <= 1'b0;
            mdata_q     <= '0;
            mrule_q     <= '0;
        end else begin
            state_q     <= state_d;
            match_buf_q <= match_buf_d;
            fill_q      <= fill_d;
            shifted_q   <= shifted_d;
            sync_q      <= sync_d;
            match_q     <= match_d;
            trig_q      <= trig_d;
            mdata_q     <= mdata_d;
            mrule_q     <= mrule_d;
        end
    end

    assign O_synchronized = sync_q;
    assign O_match        = match_q;
    assign O_trigger      = trig_q;
    assign O_matched_data = mdata_q;
    assign O_matched_rule = mrule_q;

endmodule

// File: tb/tb_trace_matcher.sv
// tb/tb_trace_matcher.sv - directed self-checking bench for trace_matcher
module tb_trace_matcher;

    localparam int B = 64;
    localparam int R = 8;

    localparam logic [63:0] PAT_A = 64'h0011_2233_4455_6677;
    localparam logic [63:0] PAT_B = 64'hDEAD_BEEF_CAFE_F00D;

    logic           trace_clk = 1'b0;
    logic           reset_i;
    logic [7:0]     I_data;
    logic           I_data_valid;
    logic           I_reset_sync;
`ifdef TRACE_MATCH_ARM_EN
    logic           I_arm;
`endif
    logic [R-1:0]   I_pattern_enable;
    logic [R-1:0]   I_trig_enable;
    logic [R*B-1:0] I_patterns;
    logic [R*B-1:0] I_masks;
    logic           O_synchronized;
    logic [R-1:0]   O_match;
    logic           O_trigger;
    logic [R*8-1:0] O_counts;
    logic [B-1:0]   O_matched_data;
    logic [2:0]     O_matched_rule;

    int tests_run    = 0;
    int tests_failed = 0;
    int trig_seen    = 0;
    int match0_seen  = 0;

    trace_matcher #(
        .pBUFFER_SIZE (B),
        .pMATCH_RULES (R)
    ) dut (
        .trace_clk        (trace_clk),
        .reset_i          (reset_i),
        .I_data           (I_data),
        .I_data_valid     (I_data_valid),
        .I_reset_sync     (I_reset_sync),
`ifdef TRACE_MATCH_ARM_EN
        .I_arm            (I_arm),
`endif
        .I_pattern_enable (I_pattern_enable),
        .I_trig_enable    (I_trig_enable),
        .I_patterns       (I_patterns),
        .I_masks          (I_masks),
        .O_synchronized   (O_synchronized),
        .O_match          (O_match),
        .O_trigger        (O_trigger),
        .O_counts         (O_counts),
        .O_matched_data   (O_matched_data),
        .O_matched_rule   (O_matched_rule)
    );

    always #5 trace_clk = ~trace_clk;

    always @(negedge trace_clk) begin
        if (O_trigger)  trig_seen++;
        if (O_match[0]) match0_seen++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge trace_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        I_data       = b;
        I_data_valid = 1'b1;
        tick();
        I_data_valid = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            I_data       = w[63-8*i -: 8];
            I_data_valid = 1'b1;
            tick();
        end
        I_data_valid = 1'b0;
    endtask

    task automatic set_rule(input int idx, input logic [63:0] pat, input logic [63:0] mask);
        I_patterns[idx*B +: B] = pat;
        I_masks[idx*B +: B]    = mask;
    endtask

    function automatic logic [7:0] cnt(input int i);
        return O_counts[i*8 +: 8];
    endfunction

    int t0;
    int m0;

    initial begin
        reset_i          = 1'b1;
        I_data           = '0;
        I_data_valid     = 1'b0;
        I_reset_sync     = 1'b0;
`ifdef TRACE_MATCH_ARM_EN
        I_arm            = 1'b0;
`endif
        I_pattern_enable = '0;
        I_trig_enable    = '0;
        I_patterns       = '0;
        I_masks          = '0;
        tick();
        tick();
        reset_i = 1'b0;
        tick();

        // 1: reset state and frame sync acquisition
        check_eq("rst_sync", O_synchronized, 0);
        check_eq("rst_counts", O_counts, 0);
        check_eq("rst_match", O_match, 0);
        check_eq("rst_trig", O_trigger, 0);
        check_eq("rst_mdata", O_matched_data, 0);
        send(8'hFF);
        send(8'hFF);
        send(8'hFF);
        send(8'h7F);
        check_eq("sync_edge1", O_synchronized, 0);
        tick();
        check_eq("sync_edge2", O_synchronized, 1);
        check_eq("sync_counts", O_counts, 0);

        // 2: single rule full match
        set_rule(0, PAT_A, '1);
        I_pattern_enable = 8'h01;
        I_trig_enable    = 8'h01;
        t0 = trig_seen;
        send_word(PAT_A);
        check_eq("r0_pre_match", O_match, 0);
        tick();
        check_eq("r0_match", O_match, 8'h01);
        check_eq("r0_trig", O_trigger, 1);
        check_eq("r0_count", cnt(0), 1);
        check_eq("r0_mdata", O_matched_data, PAT_A);
        check_eq("r0_mrule", O_matched_rule, 0);
        tick();
        check_eq("r0_match_pulse", O_match, 0);
        check_eq("r0_trig_pulse", O_trigger, 0);
        check_eq("r0_trig_once", trig_seen - t0, 1);

        // 3: two rules with identical pattern, lowest index reported
        I_pattern_enable = 8'h24;
        set_rule(2, PAT_B, '1);
        set_rule(5, PAT_B, '1);
        send_word(PAT_B);
        tick();
        check_eq("r25_match", O_match, 8'h24);
        check_eq("r25_mrule", O_matched_rule, 2);
        check_eq("r25_mdata", O_matched_data, PAT_B);
        check_eq("r25_count2", cnt(2), 1);
        check_eq("r25_count5", cnt(5), 1);
        check_eq("r25_count0", cnt(0), 1);
        check_eq("r25_no_trig", O_trigger, 0);

        // all-zero mask matches whatever the full buffer holds
        I_pattern_enable = 8'h80;
        set_rule(7, 64'h1234_5678_9ABC_DEF0, '0);
        send(8'h55);
        tick();
        check_eq("m0_match", O_match, 8'h80);
        check_eq("m0_mrule", O_matched_rule, 7);
        check_eq("m0_mdata", O_matched_data, 64'hADBE_EFCA_FEF0_0D55);
        check_eq("m0_count7", cnt(7), 1);

        // 4: 300 back-to-back matches saturate the counter
        I_pattern_enable = 8'h01;
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < 8; i++) begin
                I_data       = PAT_A[63-8*i -: 8];
                I_data_valid = 1'b1;
                tick();
            end
        end
        I_data_valid = 1'b0;
        tick();
        check_eq("sat_match", O_match, 8'h01);
        check_eq("sat_count0", cnt(0), 8'hFF);
        check_eq("sat_count2", cnt(2), 1);
        tick();
        check_eq("sat_hold", cnt(0), 8'hFF);

        // 5: resync with a same-cycle byte
        I_reset_sync = 1'b1;
        I_data       = 8'hAB;
        I_data_valid = 1'b1;
        tick();
        I_data_valid = 1'b0;
        I_reset_sync = 1'b0;
        check_eq("rs_sync", O_synchronized, 0);
        check_eq("rs_counts", O_counts, 0);
        check_eq("rs_match", O_match, 0);
        check_eq("rs_mdata", O_matched_data, PAT_A);
        check_eq("rs_mrule", O_matched_rule, 0);
        I_pattern_enable = 8'h80;
        I_trig_enable    = 8'h00;
        send(8'hFF);
        send(8'hFF);
        send(8'hFF);
        send(8'h7F);
        tick();
        check_eq("rs_resync", O_synchronized, 1);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        tick();
        check_eq("rs_fill7_nohit", O_match, 0);
        send(8'h04);
        tick();
        check_eq("rs_fill8_hit", O_match, 8'h80);
        check_eq("rs_new_mdata", O_matched_data, 64'hFFFF_FF7F_0102_0304);

`ifdef TRACE_MATCH_ARM_EN
        // 6: one-shot armed trigger
        I_pattern_enable = 8'h01;
        I_trig_enable    = 8'h01;
        set_rule(0, PAT_A, '1);
        t0 = trig_seen;
        m0 = match0_seen;
        send_word(PAT_A);
        tick();
        send_word(PAT_A);
        tick();
        tick();
        check_eq("arm_off_match", match0_seen - m0, 2);
        check_eq("arm_off_trig", trig_seen - t0, 0);
        I_arm = 1'b1;
        tick();
        I_arm = 1'b0;
        tick();
        t0 = trig_seen;
        m0 = match0_seen;
        send_word(PAT_A);
        tick();
        send_word(PAT_A);
        tick();
        tick();
        check_eq("arm_on_match", match0_seen - m0, 2);
        check_eq("arm_on_trig", trig_seen - t0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
